// File: rtl/rx_frame_scheduler_if.sv
// rtl/rx_frame_scheduler_if.sv - serialized sample word stream between scheduler and downstream consumer
//
// Signals:
//   out_data   24-bit sample word (I or Q of one channel)
//   out_valid  out_data holds a word
//   out_ready  consumer takes the word when out_valid && out_ready
//   out_first  word 0 of a frame (I of channel 0)
//   out_last   final word of a frame (Q of the last active channel)
// Modports: master = scheduler side, slave = consumer side.

interface rx_frame_scheduler_if;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_first;
    logic        out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_first,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_first,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/rx_frame_scheduler.sv
// rtl/rx_frame_scheduler.sv - gathers one I/Q sample per active receiver channel and serializes them as frames
//
// Ports:
//   clock        system clock, rising edge
//   rst          synchronous active-high reset
//   rx_strobe    per-channel one-cycle sample strobe
//   rx_data_I/Q  per-channel 24-bit I/Q samples, channel k in bits [24k+23:24k]
//   n_active     number of active channels (0 -> 1, above NRX -> NRX)
//   out_if       serialized word stream (master side)
//   overrun      sticky per-channel flag: a sample was overwritten before being framed
//   overrun_clr  clears all overrun flags
//   busy         a frame is being sent

module rx_frame_scheduler #(
    parameter int NRX = 4
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [NRX-1:0]       rx_strobe,
    input  logic [24*NRX-1:0]    rx_data_I,
    input  logic [24*NRX-1:0]    rx_data_Q,
    input  logic [3:0]           n_active,
    rx_frame_scheduler_if.master out_if,
    output logic [NRX-1:0]       overrun,
    input  logic                 overrun_clr,
    output logic                 busy
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [3:0] NRX_W = 4'(NRX);

    state_t         state_q, state_d;
    logic [3:0]     w_q, w_d;
    logic [3:0]     len_q, len_d;
    logic [NRX-1:0] pending_q, pending_d;
    logic [NRX-1:0] overrun_q, overrun_d;

    logic [23:0]    hold_i_q [NRX];
    logic [23:0]    hold_i_d [NRX];
    logic [23:0]    hold_q_q [NRX];
    logic [23:0]    hold_q_d [NRX];
    logic [23:0]    frame_i_q[NRX];
    logic [23:0]    frame_i_d[NRX];
    logic [23:0]    frame_q_q[NRX];
    logic [23:0]    frame_q_d[NRX];

    logic [3:0]     a_eff;
    logic [NRX-1:0] active;
    logic           last_word;
    logic           accept;
    logic           snap_ok;
    logic           snap;

    // Effective channel count, clamped to 1..NRX.
    always_comb begin
        a_eff = n_active;
        if (n_active == 4'd0) begin
            a_eff = 4'd1;
        end else if (n_active > NRX_W) begin
            a_eff = NRX_W;
        end
        for (int k = 0; k < NRX; k++) begin
            active[k] = (4'(k) < a_eff);
        end
    end

    // Snapshot fires from IDLE, or on the cycle the final word is accepted so the
    // next frame follows without a bubble. Inactive channels count as ready.
    always_comb begin
        last_word = (state_q == SEND) && ({1'b0, w_q} == ({len_q, 1'b0} - 5'd1));
        accept    = (state_q == SEND) && out_if.out_ready;
        snap_ok   = &(pending_q | ~active);
        snap      = snap_ok && ((state_q == IDLE) || (accept && last_word));
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (snap) begin
                    state_d = SEND;
                    w_d     = 4'd0;
                    len_d   = a_eff;
                end
            end
            SEND: begin
                if (accept) begin
                    if (last_word) begin
                        w_d = 4'd0;
                        if (snap) begin
                            len_d = a_eff;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        w_d = w_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A strobe coinciding with the snapshot lands in holding after the old value
    // was copied to the frame, and re-arms pending; only a strobe onto a pending
    // channel that is not being drained this cycle is an overrun.
    always_comb begin
        for (int k = 0; k < NRX; k++) begin
            hold_i_d[k]  = hold_i_q[k];
            hold_q_d[k]  = hold_q_q[k];
            frame_i_d[k] = frame_i_q[k];
            frame_q_d[k] = frame_q_q[k];
            if (snap) begin
                frame_i_d[k] = hold_i_q[k];
                frame_q_d[k] = hold_q_q[k];
            end
            if (rx_strobe[k] && active[k]) begin
                hold_i_d[k] = rx_data_I[24*k +: 24];
                hold_q_d[k] = rx_data_Q[24*k +: 24];
            end
            pending_d[k] = active[k] & (rx_strobe[k] | (pending_q[k] & ~snap));
            overrun_d[k] = (overrun_q[k] & ~overrun_clr)
                         | (rx_strobe[k] & active[k] & pending_q[k] & ~snap);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= IDLE;
            w_q       <= 4'd0;
            len_q     <= 4'd0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            len_q     <= len_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Data storage carries no reset; its content is only observed after a snapshot.
    always_ff @(posedge clock) begin
        for (int k = 0; k < NRX; k++) begin
            hold_i_q[k]  <= hold_i_d[k];
            hold_q_q[k]  <= hold_q_d[k];
            frame_i_q[k] <= frame_i_d[k];
            frame_q_q[k] <= frame_q_d[k];
        end
    end

    // Even word index -> I, odd -> Q of channel w/2. Driven only from registered
    // state so the word is stable while the consumer stalls.
    always_comb begin
        out_if.out_data = 24'd0;
        if (state_q == SEND) begin
            for (int k = 0; k < NRX; k++) begin
                if (w_q[3:1] == 3'(k)) begin
                    out_if.out_data = w_q[0] ? frame_q_q[k] : frame_i_q[k];
                end
            end
        end
        out_if.out_valid = (state_q == SEND);
        out_if.out_first = (state_q == SEND) && (w_q == 4'd0);
        out_if.out_last  = last_word;
        busy             = (state_q == SEND);
        overrun          = overrun_q;
    end

endmodule

// File: tb/tb_rx_frame_scheduler.sv
// tb/tb_rx_frame_scheduler.sv - directed vector bench for rx_frame_scheduler

module tb_rx_frame_scheduler;

    localparam int NRX = 4;

    logic          clock = 1'b0;
    logic          rst;
    logic [3:0]    rx_strobe;
    logic [95:0]   rx_i;
    logic [95:0]   rx_q;
    logic [3:0]    n_active;
    logic [3:0]    overrun;
    logic          overrun_clr;
    logic          busy;

    rx_frame_scheduler_if ifc ();

    rx_frame_scheduler #(.NRX(NRX)) dut (
        .clock       (clock),
        .rst         (rst),
        .rx_strobe   (rx_strobe),
        .rx_data_I   (rx_i),
        .rx_data_Q   (rx_q),
        .n_active    (n_active),
        .out_if      (ifc),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]       n_act;
        logic [3:0][23:0] i;
        logic [3:0][23:0] q;
        int               nwords;
        logic [7:0][23:0] exp;
    } vec_t;

    vec_t vecs[5];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at the negedge where word 'start' is on the bus; ready is held high.
    task automatic drain(input logic [7:0][23:0] exp, input int n, input int start);
        for (int j = start; j < n; j++) begin
            check($sformatf("valid w%0d", j), 32'(ifc.out_valid), 32'd1);
            check($sformatf("data w%0d", j), 32'(ifc.out_data), 32'(exp[j]));
            check($sformatf("first w%0d", j), 32'(ifc.out_first), 32'(j == 0));
            check($sformatf("last w%0d", j), 32'(ifc.out_last), 32'(j == n - 1));
            @(negedge clock);
        end
        check("valid after frame", 32'(ifc.out_valid), 32'd0);
        check("busy after frame", 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        n_active  = v.n_act;
        rx_i      = v.i;
        rx_q      = v.q;
        rx_strobe = 4'hF;
        @(negedge clock);
        rx_strobe = 4'h0;
        check($sformatf("v%0d latency t+1", idx), 32'(ifc.out_valid), 32'd0);
        @(negedge clock);
        drain(v.exp, v.nwords, 0);
        check($sformatf("v%0d overrun", idx), 32'(overrun), 32'd0);
    endtask

    initial begin
        vecs[0].n_act = 4'd2;
        vecs[0].i = {24'hCAFE00, 24'hDEADBE, 24'h123456, 24'h000001};
        vecs[0].q = {24'h0BAD00, 24'hBEEF00, 24'h800000, 24'hFFFFFF};
        vecs[0].nwords = 4;
        vecs[0].exp = {96'h0, 24'h800000, 24'h123456, 24'hFFFFFF, 24'h000001};

        vecs[1].n_act = 4'd4;
        vecs[1].i = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
        vecs[1].q = {24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA};
        vecs[1].nwords = 8;
        vecs[1].exp = {24'hDDDDDD, 24'h444444, 24'hCCCCCC, 24'h333333,
                       24'hBBBBBB, 24'h222222, 24'hAAAAAA, 24'h111111};

        vecs[2].n_act = 4'd0;
        vecs[2].i = {24'h999999, 24'h888888, 24'h777777, 24'h7FFFFF};
        vecs[2].q = {24'h666666, 24'h555555, 24'h444444, 24'h000000};
        vecs[2].nwords = 2;
        vecs[2].exp = {144'h0, 24'h000000, 24'h7FFFFF};

        vecs[3].n_act = 4'd9;
        vecs[3].i = {24'h400000, 24'h300000, 24'h200000, 24'h100000};
        vecs[3].q = {24'h0F0000, 24'h0E0000, 24'h0D0000, 24'h0C0000};
        vecs[3].nwords = 8;
        vecs[3].exp = {24'h0F0000, 24'h400000, 24'h0E0000, 24'h300000,
                       24'h0D0000, 24'h200000, 24'h0C0000, 24'h100000};

        vecs[4].n_act = 4'd3;
        vecs[4].i = {24'h123123, 24'h800001, 24'h000100, 24'hA5A5A5};
        vecs[4].q = {24'h321321, 24'h7FFFFE, 24'hFFFEFF, 24'h5A5A5A};
        vecs[4].nwords = 6;
        vecs[4].exp = {48'h0, 24'h7FFFFE, 24'h800001, 24'hFFFEFF,
                       24'h000100, 24'h5A5A5A, 24'hA5A5A5};

        rst           = 1'b1;
        rx_strobe     = 4'h0;
        rx_i          = '0;
        rx_q          = '0;
        n_active      = 4'd2;
        overrun_clr   = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (3) @(negedge clock);

        check("rst valid", 32'(ifc.out_valid), 32'd0);
        check("rst first", 32'(ifc.out_first), 32'd0);
        check("rst last", 32'(ifc.out_last), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst data", 32'(ifc.out_data), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        @(negedge clock);

        for (int v = 0; v < 5; v++) begin
            run_vec(vecs[v], v);
            @(negedge clock);
        end

        // Stall at word 1 for 10 cycles.
        begin
            n_active  = 4'd2;
            rx_i      = vecs[0].i;
            rx_q      = vecs[0].q;
            rx_strobe = 4'h3;
            @(negedge clock);
            rx_strobe = 4'h0;
            @(negedge clock);
            check("stall w0", 32'(ifc.out_data), 32'h000001);
            @(negedge clock);
            check("stall w1", 32'(ifc.out_data), 32'hFFFFFF);
            ifc.out_ready = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clock);
                check($sformatf("stall hold data c%0d", c), 32'(ifc.out_data), 32'hFFFFFF);
                check($sformatf("stall hold valid c%0d", c), 32'(ifc.out_valid), 32'd1);
                check($sformatf("stall hold last c%0d", c), 32'(ifc.out_last), 32'd0);
            end
            ifc.out_ready = 1'b1;
            drain(vecs[0].exp, 4, 1);
        end

        // Channel 0 overwritten before channel 1 arrives.
        begin
            n_active  = 4'd2;
            rx_i[23:0] = 24'h0000AA;
            rx_q[23:0] = 24'h0000A1;
            rx_strobe = 4'h1;
            @(negedge clock);
            rx_i[23:0] = 24'h0000BB;
            rx_q[23:0] = 24'h0000B1;
            @(negedge clock);
            rx_strobe = 4'h0;
            check("ovr flag", 32'(overrun), 32'h1);
            check("ovr no frame", 32'(ifc.out_valid), 32'd0);
            @(negedge clock);
            rx_i[47:24] = 24'h0000CC;
            rx_q[47:24] = 24'h0000DD;
            rx_strobe = 4'h2;
            @(negedge clock);
            rx_strobe = 4'h0;
            @(negedge clock);
            drain({96'h0, 24'h0000DD, 24'h0000CC, 24'h0000B1, 24'h0000BB}, 4, 0);
            check("ovr sticky", 32'(overrun), 32'h1);
            overrun_clr = 1'b1;
            @(negedge clock);
            overrun_clr = 1'b0;
            check("ovr cleared", 32'(overrun), 32'h0);
        end

        // Strobe on channel 0 in the snapshot cycle.
        begin
            n_active  = 4'd2;
            rx_i[47:0] = {24'h222000, 24'h111000};
            rx_q[47:0] = {24'h222001, 24'h111001};
            rx_strobe = 4'h3;
            @(negedge clock);
            rx_i[23:0] = 24'h333000;
            rx_q[23:0] = 24'h333001;
            rx_strobe = 4'h1;
            @(negedge clock);
            rx_strobe = 4'h0;
            drain({96'h0, 24'h222001, 24'h222000, 24'h111001, 24'h111000}, 4, 0);
            check("coinc overrun", 32'(overrun), 32'h0);
            rx_i[47:24] = 24'h444000;
            rx_q[47:24] = 24'h444001;
            rx_strobe = 4'h2;
            @(negedge clock);
            rx_strobe = 4'h0;
            @(negedge clock);
            drain({96'h0, 24'h444001, 24'h444000, 24'h333001, 24'h333000}, 4, 0);
        end

        // Strobes every 4 cycles, A=2: frames back to back.
        begin
            int got;
            int first_c;
            int last_c;
            logic [23:0] expw;
            got     = 0;
            first_c = -1;
            last_c  = -1;
            n_active = 4'd2;
            for (int c = 0; c < 20; c++) begin
                if (ifc.out_valid) begin
                    if (first_c < 0) first_c = c;
                    last_c = c;
                    expw = {8'h00, 8'(got / 4), 8'(got % 4 + 1)};
                    check($sformatf("b2b data %0d", got), 32'(ifc.out_data), 32'(expw));
                    check($sformatf("b2b last %0d", got), 32'(ifc.out_last), 32'(got % 4 == 3));
                    got++;
                end
                rx_strobe = 4'h0;
                if ((c % 4 == 0) && (c / 4 < 4)) begin
                    rx_i[47:0] = {8'h00, 8'(c / 4), 8'h03, 8'h00, 8'(c / 4), 8'h01};
                    rx_q[47:0] = {8'h00, 8'(c / 4), 8'h04, 8'h00, 8'(c / 4), 8'h02};
                    rx_strobe  = 4'h3;
                end
                @(negedge clock);
            end
            check("b2b word count", 32'(got), 32'd16);
            check("b2b first cycle", 32'(first_c), 32'd2);
            check("b2b no bubble", 32'(last_c - first_c + 1), 32'd16);
            check("b2b overrun", 32'(overrun), 32'h0);
        end

        // Reset at word 2 of a 4-channel frame.
        begin
            n_active  = 4'd4;
            rx_i      = vecs[1].i;
            rx_q      = vecs[1].q;
            rx_strobe = 4'hF;
            @(negedge clock);
            rx_strobe = 4'h0;
            @(negedge clock);
            rx_strobe = 4'h1;
            @(negedge clock);
            rx_strobe = 4'h1;
            @(negedge clock);
            rx_strobe = 4'h0;
            check("rstseq w2", 32'(ifc.out_data), 32'h222222);
            check("rstseq overrun set", 32'(overrun), 32'h1);
            rst = 1'b1;
            @(negedge clock);
            rst = 1'b0;
            check("rstseq valid", 32'(ifc.out_valid), 32'd0);
            check("rstseq busy", 32'(busy), 32'd0);
            check("rstseq overrun", 32'(overrun), 32'h0);
            check("rstseq data", 32'(ifc.out_data), 32'h0);
            repeat (3) @(negedge clock);
            check("rstseq stays idle", 32'(ifc.out_valid), 32'd0);
            rx_i[71:0] = {24'h030303, 24'h020202, 24'h010101};
            rx_q[71:0] = {24'h0C0C0C, 24'h0B0B0B, 24'h0A0A0A};
            rx_strobe = 4'h7;
            @(negedge clock);
            rx_strobe = 4'h0;
            repeat (3) @(negedge clock);
            check("rstseq partial idle", 32'(ifc.out_valid), 32'd0);
            rx_i[95:72] = 24'h040404;
            rx_q[95:72] = 24'h0D0D0D;
            rx_strobe = 4'h8;
            @(negedge clock);
            rx_strobe = 4'h0;
            @(negedge clock);
            drain({24'h0D0D0D, 24'h040404, 24'h0C0C0C, 24'h030303,
                   24'h0B0B0B, 24'h020202, 24'h0A0A0A, 24'h010101}, 8, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_frame_scheduler.md
RX_FRAME_SCHEDULER -- requirements
Module: rx_frame_scheduler

Interface
REQ-001 Parameter NRX, default 4, range 1..8: number of receiver channels served.
REQ-002 clock  in  1  system clock, 73.728 MHz; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rx_strobe  in  NRX  per-channel sample strobe from receiver out_strobe; 1-cycle pulse.
REQ-005 rx_data_I  in  24*NRX  channel k I sample in bits [24k+23:24k]; valid when rx_strobe[k]=1.
REQ-006 rx_data_Q  in  24*NRX  channel k Q sample, same packing as rx_data_I.
REQ-007 n_active  in  4  number of active channels; 0 means 1; values above NRX mean NRX.
REQ-008 out_data  out  24  serialized sample word.
REQ-009 out_valid  out  1  out_data valid.
REQ-010 out_ready  in  1  downstream accepts the word when out_valid=1 and out_ready=1.
REQ-011 out_first  out  1  high with word 0 (I of channel 0) of a frame.
REQ-012 out_last  out  1  high with the final word (Q of channel A-1) of a frame.
REQ-013 overrun  out  NRX  sticky per-channel overrun flags.
REQ-014 overrun_clr  in  1  clears all overrun flags.
REQ-015 busy  out  1  high while state is SEND.

Function
REQ-016 Each channel has a 48-bit holding register plus a pending flag; rx_strobe[k]=1 loads I/Q into holding k and sets pending[k] at that clock edge.
REQ-017 Strobes on channels k >= A (A = effective n_active) are ignored; pending[k] for those channels is held at 0.
REQ-018 States: IDLE and SEND only.
REQ-019 IDLE: when pending[k]=1 for all k < A, snapshot holding[0..A-1] into the frame buffer, latch A as frame length, clear those pending flags, go to SEND; otherwise remain in IDLE.
REQ-020 A is sampled only at snapshot; a change to n_active during SEND affects only the next frame.
REQ-021 SEND: word index w runs 0..2A-1; out_data = I of channel w/2 when w is even, Q of channel w/2 when w is odd; out_valid=1.
REQ-022 out_first = out_valid and w=0; out_last = out_valid and w=2A-1.
REQ-023 w advances only on out_valid and out_ready; out_data, out_first and out_last are stable while out_ready=0.
REQ-024 When the last word is accepted: if the IDLE snapshot condition holds in that cycle, snapshot immediately and stay in SEND with w=0 (back-to-back, no bubble); otherwise go to IDLE with out_valid=0.
REQ-025 Latency: all A strobes coincide in cycle t, state IDLE, not blocked -> out_valid=1 with word 0 in cycle t+2.
REQ-026 A strobe on channel k in the same cycle as a snapshot that clears pending[k]: the frame takes the old holding value, the new sample loads holding k, pending[k] ends at 1, no overrun.
REQ-027 A strobe on channel k while pending[k]=1 and not being cleared in that cycle: new sample overwrites holding k and overrun[k] is set.
REQ-028 The frame buffer is unaffected by strobes during SEND.
REQ-029 overrun_clr clears all flags; an overrun event in the same cycle takes priority (flag ends at 1).
REQ-030 Samples pass through unmodified: no rounding, no sign change, bit-exact.

Reset
REQ-031 rst=1 -> state IDLE, w=0, all pending=0, all overrun=0, out_valid=0, out_first=0, out_last=0, busy=0, out_data=0; holding registers and frame buffer are don't-care.
REQ-032 rst asserted mid-frame aborts the frame; no word is emitted after rst, and the first frame after rst needs fresh strobes on all A channels.

Verification
REQ-033 NRX=4, n_active=2, out_ready=1, simultaneous strobes with I0=0x000001, Q0=0xFFFFFF, I1=0x123456, Q1=0x800000 in cycle t -> cycles t+2..t+5 output 000001, FFFFFF, 123456, 800000; first at t+2, last at t+5.
REQ-034 Same frame with out_ready=0 for 10 cycles at word 1 -> out_data holds 0xFFFFFF and out_valid stays 1; sequence resumes unchanged when out_ready=1.
REQ-035 Channel 0 strobed twice before channel 1 strobes once -> overrun=4'b0001; frame carries the second channel 0 sample; overrun_clr -> overrun=0.
REQ-036 Strobes every 4 cycles with A=2 and out_ready=1 -> frames back-to-back with no overrun and no lost sample; n_active=0 -> 2-word frames from channel 0 only.
REQ-037 rst pulse at word 2 of a 4-channel frame -> out_valid=0 next cycle, busy=0, overrun=0; next frame emitted only after new strobes on all channels.
